// File: rtl/vec_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : vec_serializer_if
// Purpose  : Vector-in / lane-out valid/ready bundle for vec_serializer.
// Revision : 1.0
// ============================================================================
interface vec_serializer_if #(
   parameter int width_p = 8,
   parameter int depth_p = 8
) ();
   logic signed [depth_p-1:0][width_p-1:0] data_i;
   logic                                   valid_i;
   logic                                   ready_o;
   logic                                   valid_o;
   logic signed [width_p-1:0]              data_o;
   logic                                   last_o;
   logic                                   ready_i;

   modport slave (
      input  data_i, valid_i, ready_i,
      output ready_o, valid_o, data_o, last_o
   );

   modport master (
      output data_i, valid_i, ready_i,
      input  ready_o, valid_o, data_o, last_o
   );
endinterface
`default_nettype wire

// File: rtl/vec_serializer.sv
`default_nettype none
// ============================================================================
// Module   : vec_serializer
// Purpose  : Accepts one depth_p-lane vector per handshake, emits lanes 0..N-1.
//            Define VEC_SERIALIZER_B2B_EN for gapless back-to-back vectors.
// Revision : 1.0
// ============================================================================
module vec_serializer #(
   parameter int width_p = 8,
   parameter int depth_p = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   vec_serializer_if.slave bus
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   localparam int               IDX_W      = $clog2(depth_p);
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(depth_p - 1);

   state_t                          state_q;
   logic [depth_p-1:0][width_p-1:0] hold_q;
   logic [IDX_W-1:0]                idx_q;
   logic [width_p-1:0]              data_q;
   logic                            valid_q;
   logic                            last_q;

   logic                            w_ready;
   logic                            w_in_hs;
   logic                            w_out_hs;
   logic [IDX_W-1:0]                w_idx_inc;

`ifdef VEC_SERIALIZER_B2B_EN
   // last_q is only ever high in SEND, so this reduces to ready_i & last_o there.
   assign w_ready = (state_q == S_IDLE) | (bus.ready_i & last_q);
`else
   assign w_ready = (state_q == S_IDLE);
`endif

   assign w_in_hs   = bus.valid_i & w_ready;
   assign w_out_hs  = valid_q & bus.ready_i;
   assign w_idx_inc = idx_q + 1'b1;

   assign bus.ready_o = w_ready;
   assign bus.valid_o = valid_q;
   assign bus.data_o  = data_q;
   assign bus.last_o  = last_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_in_hs) begin
                  hold_q  <= bus.data_i;
                  idx_q   <= '0;
                  data_q  <= bus.data_i[0];
                  valid_q <= 1'b1;
                  last_q  <= 1'b0;
                  state_q <= S_SEND;
               end
            end
            S_SEND: begin
               if (w_out_hs) begin
                  if (idx_q != c_LAST_IDX) begin
                     idx_q  <= w_idx_inc;
                     data_q <= hold_q[w_idx_inc];
                     last_q <= (w_idx_inc == c_LAST_IDX);
                  end else if (w_in_hs) begin
                     // Only reachable with the back-to-back path compiled in.
                     hold_q  <= bus.data_i;
                     idx_q   <= '0;
                     data_q  <= bus.data_i[0];
                     last_q  <= 1'b0;
                  end else begin
                     idx_q   <= '0;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               idx_q   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
